// File: rtl/comp_serie_n_pkg.sv
// Shared types for the serial MSB-first magnitude comparator: FSM encoding,
// result bundle and the chunk-index width helper.
package comp_serie_n_pkg;

    typedef enum logic [1:0] {
        ST_REPOSO  = 2'd0,
        ST_COMPARA = 2'd1,
        ST_FIN     = 2'd2
    } estado_t;

    typedef struct packed {
        logic mayor;
        logic igual;
        logic menor;
    } resultado_t;

    // A single-chunk configuration still keeps a 1-bit index register.
    function automatic int idx_width(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/comp_serie_n_segmento.sv
// Combinational CHUNK-bit magnitude compare, built as the 1-bit greater/less
// cascade walked from the MSB down; optional sign-bit inversion for signed mode.
module comp_segmento
    import comp_serie_n_pkg::*;
#(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_invierte_msb,
    output logic             o_mayor,
    output logic             o_igual,
    output logic             o_menor
);

    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic             w_gt;
    logic             w_lt;

    always_comb begin
        // NOTE: every variable gets a value before any branch or loop so no latch is inferred.
        w_a  = i_a;
        w_b  = i_b;
        w_gt = 1'b0;
        w_lt = 1'b0;
        if (i_invierte_msb) begin
            w_a[CHUNK-1] = ~i_a[CHUNK-1];
            w_b[CHUNK-1] = ~i_b[CHUNK-1];
        end
        // Once a stage has decided, lower bits can no longer change the verdict.
        for (int i = CHUNK - 1; i >= 0; i--) begin
            w_gt = w_gt | (~w_lt &  w_a[i] & ~w_b[i]);
            w_lt = w_lt | (~w_gt & ~w_a[i] &  w_b[i]);
        end
    end

    assign o_mayor = w_gt;
    assign o_menor = w_lt;
    assign o_igual = ~w_gt & ~w_lt;

endmodule

// File: rtl/comp_serie_n.sv
// Serial magnitude comparator: CHUNK bits per clock, MSB chunk first, stops at
// the first unequal chunk. Unsigned or two's-complement, start/ocupado/listo handshake.
module comp_serie_n
    import comp_serie_n_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             con_signo,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ocupado,
    output logic             listo,
    output logic             mayor,
    output logic             igual,
    output logic             menor
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = idx_width(NCHUNK);
    localparam int NSLOT  = 1 << IDXW;
    localparam logic [IDXW-1:0] IDX_MSB = IDXW'(NCHUNK - 1);

    estado_t          r_estado;
    estado_t          w_estado_sig;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signo;
    logic [IDXW-1:0]  r_idx;
    resultado_t       r_res;

    logic             w_cargar;
    logic             w_decidido;
    logic             w_invierte;
    logic [CHUNK-1:0] w_sl_a;
    logic [CHUNK-1:0] w_sl_b;
    logic             w_seg_mayor;
    logic             w_seg_igual;
    logic             w_seg_menor;

    // Slice table padded to a power of two so the index selects without width mismatch;
    // the padding slots are unreachable because r_idx never exceeds NCHUNK-1.
    logic [CHUNK-1:0] w_ch_a [NSLOT];
    logic [CHUNK-1:0] w_ch_b [NSLOT];

    for (genvar g = 0; g < NSLOT; g++) begin : g_slice
        if (g < NCHUNK) begin : g_real
            assign w_ch_a[g] = r_a[g*CHUNK +: CHUNK];
            assign w_ch_b[g] = r_b[g*CHUNK +: CHUNK];
        end else begin : g_pad
            assign w_ch_a[g] = '0;
            assign w_ch_b[g] = '0;
        end
    end

    assign w_sl_a     = w_ch_a[r_idx];
    assign w_sl_b     = w_ch_b[r_idx];
    assign w_invierte = r_signo & (r_idx == IDX_MSB);

    comp_segmento #(.CHUNK(CHUNK)) u_segmento (
        .i_a            (w_sl_a),
        .i_b            (w_sl_b),
        .i_invierte_msb (w_invierte),
        .o_mayor        (w_seg_mayor),
        .o_igual        (w_seg_igual),
        .o_menor        (w_seg_menor)
    );

    always_comb begin
        w_estado_sig = r_estado;
        w_cargar     = 1'b0;
        w_decidido   = 1'b0;
        unique case (r_estado)
            ST_REPOSO, ST_FIN: begin
                if (start) begin
                    w_cargar     = 1'b1;
                    w_estado_sig = ST_COMPARA;
                end else begin
                    w_estado_sig = ST_REPOSO;
                end
            end
            ST_COMPARA: begin
                if (!w_seg_igual || (r_idx == '0)) begin
                    w_decidido   = 1'b1;
                    w_estado_sig = ST_FIN;
                end
            end
            default: w_estado_sig = ST_REPOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_estado <= ST_REPOSO;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_signo <= 1'b0;
            r_idx   <= '0;
            r_res   <= '0;
        end else begin
            if (w_cargar) begin
                r_a     <= a;
                r_b     <= b;
                r_signo <= con_signo;
                r_idx   <= IDX_MSB;
            end else if ((r_estado == ST_COMPARA) && !w_decidido) begin
                r_idx   <= r_idx - 1'b1;
            end
            // On an all-equal finish the segment reports igual=1 with mayor=menor=0.
            if (w_decidido) begin
                r_res <= '{mayor: w_seg_mayor, igual: w_seg_igual, menor: w_seg_menor};
            end
        end
    end

    assign ocupado = (r_estado == ST_COMPARA);
    assign listo   = (r_estado == ST_FIN);
    assign mayor   = r_res.mayor;
    assign igual   = r_res.igual;
    assign menor   = r_res.menor;

endmodule

// File: tb/tb_comp_serie_n.sv
// Bench for comp_serie_n: directed table and corner sequences on 8/2, plus
// random operands on 8/2, 8/8 and 6/1 checked against an arithmetic model.
module tb_comp_serie_n;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [2:0] res;
        int         lat;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int W = (g == 2) ? 6 : 8;
        localparam int C = (g == 0) ? 2 : ((g == 1) ? 8 : 1);
        localparam int N = W / C;

        logic         rst = 1'b1;
        logic         start = 1'b0;
        logic         con_signo = 1'b0;
        logic [W-1:0] a = '0;
        logic [W-1:0] b = '0;
        logic         ocupado, listo, mayor, igual, menor;
        logic         done = 1'b0;

        comp_serie_n #(.WIDTH(W), .CHUNK(C)) dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .con_signo (con_signo),
            .a         (a),
            .b         (b),
            .ocupado   (ocupado),
            .listo     (listo),
            .mayor     (mayor),
            .igual     (igual),
            .menor     (menor)
        );

        // Reference: integer compare plus "how many MSB chunks until a difference shows".
        task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                             output logic [2:0] res, output int lat);
            longint vx, vy;
            logic [W-1:0] d;
            vx = longint'(x);
            vy = longint'(y);
            if (s && x[W-1]) vx = vx - (longint'(1) << W);
            if (s && y[W-1]) vy = vy - (longint'(1) << W);
            res = (vx > vy) ? 3'b100 : ((vx == vy) ? 3'b010 : 3'b001);
            d   = x ^ y;
            lat = N + 1;
            for (int j = N; j >= 1; j--)
                if ((d >> (W - j * C)) != '0) lat = j + 1;
        endtask

        task automatic do_reset();
            rst   = 1'b1;
            start = 1'b0;
            repeat (3) @(negedge clk);
            check($sformatf("c%0d_reset_state", g), {ocupado, listo, mayor, igual, menor}, 5'b0);
            rst = 1'b0;
        endtask

        task automatic do_cmp(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic ts,
                              output logic [2:0] res, output int lat, output int occ,
                              output logic held);
            logic [2:0] prev;
            int cyc;
            @(negedge clk);
            prev      = {mayor, igual, menor};
            a         = ta;
            b         = tbv;
            con_signo = ts;
            start     = 1'b1;
            @(negedge clk);
            start = 1'b0;
            cyc   = 1;
            occ   = 0;
            held  = 1'b1;
            while (!listo && cyc < 2 * N + 4) begin
                occ += int'(ocupado);
                if ({mayor, igual, menor} !== prev) held = 1'b0;
                @(negedge clk);
                cyc++;
            end
            occ += int'(ocupado);
            lat  = listo ? cyc : -1;
            res  = {mayor, igual, menor};
        endtask

        task automatic run_and_check(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                                     input logic ts, input logic [2:0] exp_res, input int exp_lat);
            logic [2:0] res;
            int lat, occ;
            logic held;
            do_cmp(ta, tbv, ts, res, lat, occ, held);
            check({tag, "_res"}, res, exp_res);
            check({tag, "_lat"}, lat, exp_lat);
            check({tag, "_ocupado_cycles"}, occ, exp_lat - 1);
            check({tag, "_held"}, held, 1'b1);
        endtask

        task automatic random_phase(input int count);
            logic [W-1:0] ta, tbv, oh;
            logic ts;
            logic [2:0] er;
            int el;
            for (int i = 0; i < count; i++) begin
                ta = W'($urandom);
                ts = 1'($urandom);
                oh = '0;
                oh[$urandom_range(W - 1, 0)] = 1'b1;
                case ($urandom_range(3, 0))
                    0:       tbv = ta;
                    1:       tbv = ta ^ oh;
                    default: tbv = W'($urandom);
                endcase
                model(ta, tbv, ts, er, el);
                run_and_check($sformatf("c%0d_rnd%0d", g, i), ta, tbv, ts, er, el);
            end
        endtask

        if (g == 0) begin : g_dir
            initial begin
                vec_t tbl[11];
                int   early;
                int   lc;
                tbl[0]  = '{8'hA5, 8'h35, 1'b0, 3'b100, 2};
                tbl[1]  = '{8'h3C, 8'h3C, 1'b0, 3'b010, 5};
                tbl[2]  = '{8'h12, 8'h13, 1'b0, 3'b001, 5};
                tbl[3]  = '{8'h80, 8'h01, 1'b1, 3'b001, 2};
                tbl[4]  = '{8'h80, 8'h01, 1'b0, 3'b100, 2};
                tbl[5]  = '{8'hFF, 8'h00, 1'b0, 3'b100, 2};
                tbl[6]  = '{8'h00, 8'hFF, 1'b0, 3'b001, 2};
                tbl[7]  = '{8'h7F, 8'h80, 1'b1, 3'b100, 2};
                tbl[8]  = '{8'hFE, 8'hFF, 1'b1, 3'b001, 5};
                tbl[9]  = '{8'h40, 8'h44, 1'b0, 3'b001, 4};
                tbl[10] = '{8'hC0, 8'h40, 1'b1, 3'b001, 2};

                do_reset();
                for (int i = 0; i < 11; i++)
                    run_and_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].s,
                                  tbl[i].res, tbl[i].lat);

                // start held high: FF/00 then 00/FF back to back, listo two cycles apart
                @(negedge clk);
                a = 8'hFF; b = 8'h00; con_signo = 1'b0; start = 1'b1;
                @(negedge clk);
                check("b2b_c1_ocupado", {ocupado, listo}, 2'b10);
                a = 8'h00; b = 8'hFF;
                @(negedge clk);
                check("b2b_c2_first", {listo, mayor, igual, menor}, 4'b1100);
                @(negedge clk);
                check("b2b_c3_busy", {ocupado, listo}, 2'b10);
                start = 1'b0;
                @(negedge clk);
                check("b2b_c4_second", {listo, mayor, igual, menor}, 4'b1001);

                // start toggled with other operands during an equal compare is ignored
                @(negedge clk);
                a = 8'h3C; b = 8'h3C; start = 1'b1;
                early = 0;
                for (int c = 1; c <= 4; c++) begin
                    @(negedge clk);
                    early += int'(listo);
                    start = (c == 1 || c == 3);
                    a = 8'($urandom);
                    b = ~a;
                end
                @(negedge clk);
                check("ignore_start_early_listo", early, 0);
                check("ignore_start_result", {listo, mayor, igual, menor}, 4'b1010);
                start = 1'b0;

                // leave menor set, then abort an equal compare in its second COMPARA cycle
                run_and_check("pre_abort", 8'h01, 8'h02, 1'b0, 3'b001, 5);
                @(negedge clk);
                a = 8'h3C; b = 8'h3C; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check("abort_outputs", {ocupado, listo, mayor, igual, menor}, 5'b0);
                rst = 1'b0;
                lc = 0;
                repeat (6) begin
                    @(negedge clk);
                    lc += int'(listo);
                end
                check("abort_no_listo", lc, 0);
                run_and_check("post_abort", 8'h12, 8'h13, 1'b0, 3'b001, 5);

                random_phase(300);
                done = 1'b1;
            end
        end else begin : g_rnd
            initial begin
                do_reset();
                random_phase(300);
                done = 1'b1;
            end
        end
    end

    initial begin
        int waited;
        waited = 0;
        while (!(cfg[0].done && cfg[1].done && cfg[2].done) && waited < 60000) begin
            @(posedge clk);
            waited++;
        end
        check("all_configs_done", {cfg[0].done, cfg[1].done, cfg[2].done}, 3'b111);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/comp_serie_n.md
Name: comp_serie_n

Overview:
- Sequential, parametrised successor of the 1-/2-bit magnitude comparators.
- Compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, and terminates early on the first unequal chunk.
- Supports unsigned and two's-complement modes and uses a start/ocupado/listo handshake.
- Sits beside the ALU datapath, where a full-width combinational compare is too costly.

Parameters:
- WIDTH, 8: operand width in bits. Must be a multiple of CHUNK and at least 2.
- CHUNK, 2: bits compared per cycle, range 1..WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a comparison. Sampled only when ocupado=0.
- con_signo  input  1  1 = two's-complement compare, 0 = unsigned. Latched with the operands.
- a  input  WIDTH  operand A. Latched on an accepted start.
- b  input  WIDTH  operand B. Latched on an accepted start.
- ocupado  output  1  high while a comparison is in progress.
- listo  output  1  one-cycle pulse: results are updated this cycle.
- mayor  output  1  A > B. Registered and held until the next listo.
- igual  output  1  A == B. Registered and held until the next listo.
- menor  output  1  A < B. Registered and held until the next listo.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to REPOSO.
  - ocupado=0, listo=0, mayor=0, igual=0, menor=0.
  - The chunk index and latched operands are cleared.
  - rst has priority over start and over any in-flight comparison (abort, no listo).
- States:
  - REPOSO: idle.
  - COMPARA: ocupado=1.
  - FIN: listo=1 for exactly one cycle, ocupado=0.
- REPOSO/FIN with start=1:
  - Latch a, b and con_signo; set the index to chunk NCHUNK-1 (MSB chunk).
  - Next state is COMPARA.
  - FIN with start=1 therefore gives back-to-back operation with no idle cycle.
- FIN with start=0: next state is REPOSO.
- start while in COMPARA is ignored; the operands in flight are unaffected.
- COMPARA, each cycle, on the current chunk (unsigned compare of CHUNK-bit slices):
  - If the chunks are unequal: register mayor/menor from that chunk, set igual=0, go to FIN.
  - If equal and the index is 0: register igual=1, mayor=0, menor=0, go to FIN.
  - If equal and the index is >0: decrement the index and stay in COMPARA.
- Signed mode: on the MSB chunk only, the sign bit of both slices is inverted before comparing. This is equivalent to a signed compare. Lower chunks are always unsigned.
- Latency:
  - With start high in cycle 0 and the decision taking k chunks (1..NCHUNK), listo is high in cycle k+1.
  - Worst case is NCHUNK+1 cycles; best case is 2.
- Invariant: exactly one of mayor/igual/menor is 1 in every cycle after the first listo; before the first listo (after reset) all three are 0.
- Outputs keep their old values during COMPARA and change only in the cycle listo=1.
- CHUNK=WIDTH degenerates to a single COMPARA cycle (latency 2).
- The index register is sized clog2(NCHUNK) with a minimum of 1 bit.

Decomposition:
- Shared include comp_defs.vh:
  - State encodings ST_REPOSO=2'd0, ST_COMPARA=2'd1, ST_FIN=2'd2.
  - Macro for the index width.
- Sub-module comp_segmento (parameter CHUNK): purely combinational.
  - Inputs: two CHUNK-bit slices plus an invert_msb flag.
  - Outputs: mayor/igual/menor.
  - Built by generalising the existing gate-level 1-bit cascade.
- The top level holds the FSM, operand registers, index and result registers, and selects the slices with an indexed part-select.

Test Plan (WIDTH=8, CHUNK=2 unless noted):
- a=8'hA5, b=8'h35, con_signo=0, start pulse in cycle 0 -> decided on chunk 3 (10 vs 00), listo in cycle 2, mayor=1 igual=0 menor=0, ocupado high in cycle 1 only.
- a=b=8'h3C -> four COMPARA cycles, listo in cycle 5, igual=1. Then a=8'h12, b=8'h13 -> decided on the last chunk, listo 5 cycles after start, menor=1.
- Signed: a=8'h80, b=8'h01, con_signo=1 -> menor=1 at latency 2. Same operands with con_signo=0 -> mayor=1.
- start held high continuously with pairs (8'hFF,8'h00), (8'h00,8'hFF) -> results mayor then menor, listo 2 cycles apart. A start toggled during COMPARA with different a/b has no effect on the result.
- rst=1 in the second COMPARA cycle of an equal-operand compare -> next cycle all outputs 0, no listo. A new start afterwards completes normally.
- Parameter sweep: WIDTH=8, CHUNK=8 and WIDTH=6, CHUNK=1, with exhaustive or random operands in both modes -> outputs match the reference operators >, ==, < (signed/unsigned), and latency equals the chunk index of the first difference +1 (all chunks +1 when equal).
